mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 start  in  1  request; sampled only in IDLE.
REQ-004 md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-005 data1  in  32  multiplicand / dividend; sampled with start.
REQ-006 data2  in  32  multiplier / divisor; sampled with start.
REQ-007 hi_we  in  1  MTHI write enable.
REQ-008 lo_we  in  1  MTLO write enable.
REQ-009 wdata  in  32  MTHI/MTLO write data.
REQ-010 busy  out  1  high while an operation is in flight.
REQ-011 done  out  1  one-cycle pulse in the cycle new HI/LO values first become visible.
REQ-012 hi  out  32  HI register; registered output.
REQ-013 lo  out  32  LO register; registered output.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC, FIX.
REQ-015 IDLE with start=1 -> latch operands as magnitudes (absolute values for MULT/DIV), latch result signs, load counter=31, go to CALC.
REQ-016 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; at counter=0 go to FIX, else decrement.
REQ-017 FIX SHALL apply sign correction, write HI/LO, assert done, and return to IDLE.
REQ-018 busy SHALL equal (state != IDLE); start at edge N -> busy high N+1..N+33, done and new HI/LO at N+34 (busy low), total 34-cycle latency.
REQ-019 start while busy SHALL be ignored, with no queuing.
REQ-020 MULT/MULTU: {hi,lo} = full 64-bit signed/unsigned product; no overflow indication.
REQ-021 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder carrying the dividend's sign.
REQ-022 Divisor zero (DIV or DIVU): lo = 32'hFFFFFFFF, hi = data1; full latency; no exception.
REQ-023 DIV 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0.
REQ-024 hi_we/lo_we in IDLE: register <= wdata at next edge.
REQ-025 hi_we/lo_we while busy: ignored.
REQ-026 start together with hi_we/lo_we in IDLE: both accepted; the FIX write later overwrites.
REQ-027 hi/lo SHALL hold their values between writes and during CALC, with no intermediate values visible.
REQ-028 Operand changes after the start cycle SHALL NOT affect the result.

Reset
REQ-029 rst SHALL force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, immediately and asynchronously.
REQ-030 rst mid-operation SHALL abort the operation, with no done pulse and no HI/LO update after release.
REQ-031 The first start after rst deassertion SHALL behave identically to the first start after power-up.

Structure
REQ-032 Shared package mdu_pkg SHALL hold the md_op encodings, the FSM state enum and MDU_STEPS=32.
REQ-033 The block SHALL be a single module with no sub-module; the multiply and divide datapaths SHALL share one 64-bit accumulator/shift register and one 33-bit adder/subtractor.

Verification
REQ-034 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> after 34 cycles hi=32'hFFFFFFFE, lo=32'h00000001, done pulses once.
REQ-035 MULT -3 x 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-036 DIVU 100/0 -> lo=32'hFFFFFFFF, hi=100; DIV 32'h80000000/-1 -> lo=32'h80000000, hi=0.
REQ-037 Second start plus hi_we with wdata=5 while busy -> both ignored, result of first op only, single done pulse.
REQ-038 IDLE lo_we with wdata=32'hA5A5A5A5 -> lo=32'hA5A5A5A5 next cycle, hi unchanged, busy stays 0.
REQ-039 rst asserted at cycle 10 of a DIVU -> busy, hi, lo = 0 immediately; no done pulse; next MULTU 6x7 gives lo=42, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states,
// iteration count and a small conditional-negate helper.
package mdu_pkg;

  localparam int MDU_STEPS = 32;
  localparam int CNT_W     = $clog2(MDU_STEPS);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  function automatic logic [31:0] neg_if32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// Magnitudes are processed radix-2 over 32 cycles; signs are applied in FIX.
module mdu
  import mdu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [31:0]      data1,
  input  logic [31:0]      data2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [31:0]      wdata,
  output logic             busy,
  output logic             done,
  output logic [31:0]      hi,
  output logic [31:0]      lo,
  output mdu_state_e       dbg_state
);

  // Handshake: start is a request honoured only while busy is low; requests
  // seen while busy are dropped, and done pulses once per accepted request.

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       acc_q, acc_d;
  logic [31:0]       opb_q, opb_d;
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              done_q, done_d;

  logic              signed_op;
  logic              sign1, sign2;
  logic [31:0]       mag1, mag2;
  logic [32:0]       add_a, add_b;
  logic              add_cin;
  logic [33:0]       add_res;
  logic [63:0]       acc_neg;

  // Operand conditioning for a new request.
  always_comb begin
    signed_op = (md_op == OP_MULT) || (md_op == OP_DIV);
    sign1     = signed_op & data1[31];
    sign2     = signed_op & data2[31];
    mag1      = neg_if32(data1, sign1);
    mag2      = neg_if32(data2, sign2);
  end

  // Shared 33-bit adder: adds the multiplicand or subtracts the divisor.
  always_comb begin
    add_a   = is_div_q ? acc_q[63:31] : {1'b0, acc_q[63:32]};
    add_b   = is_div_q ? ~{1'b0, opb_q} : {1'b0, opb_q};
    add_cin = is_div_q;
    add_res = {1'b0, add_a} + {1'b0, add_b} + {33'd0, add_cin};
    acc_neg = ~acc_q + 64'd1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          acc_d    = {32'd0, mag1};
          opb_d    = mag2;
          is_div_d = md_op[1];
          // A zero divisor must yield an all-ones quotient regardless of sign.
          neg_lo_d = (sign1 ^ sign2) & ~(md_op[1] && (data2 == 32'd0));
          neg_hi_d = sign1;
          cnt_d    = CNT_W'(MDU_STEPS - 1);
          state_d  = ST_CALC;
        end
      end

      ST_CALC: begin
        if (is_div_q) begin
          if (add_res[33]) acc_d = {add_res[31:0], acc_q[30:0], 1'b1};
          else             acc_d = {acc_q[62:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {add_res[32:0], acc_q[31:1]};
          else          acc_d = {1'b0, acc_q[63:32], acc_q[31:1]};
        end
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end

      ST_FIX: begin
        if (is_div_q) begin
          lo_d = neg_if32(acc_q[31:0], neg_lo_q);
          hi_d = neg_if32(acc_q[63:32], neg_hi_q);
        end else begin
          {hi_d, lo_d} = neg_lo_q ? acc_neg : acc_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases, disturbance while busy,
// mid-operation reset and randomized operations against an arithmetic model.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] data1, data2;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;
  mdu_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi, m_lo;

  mdu dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .md_op     (md_op),
    .data1     (data1),
    .data2     (data2),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: {hi, lo} from plain arithmetic on the operands.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int     sa, sb, sq, sr;
    longint la, lb;
    logic [31:0] uq, ur;
    sa = a; sb = b;
    case (op)
      2'b00: begin la = longint'(sa); lb = longint'(sb); return 64'(la * lb); end
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        sq = sa / sb;
        sr = sa % sb;
        return {32'(sr), 32'(sq)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // driver: issue one operation and follow it to completion
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb, input bit we_start);
    logic [63:0] exp;
    int  n;
    bit  busy_bad, hold_bad, extra_done;
    exp = ref_model(op, a, b);
    md_op = op; data1 = a; data2 = b; start = 1'b1;
    if (we_start) begin hi_we = 1'b1; wdata = 32'hDEADBEEF; end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    data1 = $urandom; data2 = $urandom; md_op = 2'($urandom_range(0, 3));
    if (we_start) begin
      m_hi = 32'hDEADBEEF;
      check({tag, "_we_with_start"}, hi, m_hi);
    end
    n = 1; busy_bad = 0; hold_bad = 0;
    while (n < 40 && done !== 1'b1) begin
      if (busy !== 1'b1) busy_bad = 1;
      if (hi !== m_hi || lo !== m_lo) hold_bad = 1;
      if (disturb && n == 5) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'd5;
      end else if (disturb && n == 6) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd34);
    check({tag, "_busy_while_calc"}, 32'(busy_bad), 32'd0);
    check({tag, "_hold_while_calc"}, 32'(hold_bad), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_hi"}, hi, exp[63:32]);
    check({tag, "_lo"}, lo, exp[31:0]);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    extra_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== m_hi || lo !== m_lo) extra_done = 1;
    end
    check({tag, "_quiet_after_done"}, 32'(extra_done), 32'd0);
  endtask

  initial begin
    bit quiet_bad;
    rst = 1'b1; start = 1'b0; md_op = 2'b00; data1 = '0; data2 = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // directed corner cases
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    check("multu_max_hi_const", hi, 32'hFFFFFFFE);
    check("multu_max_lo_const", lo, 32'h00000001);
    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 0, 0);
    check("mult_neg_hi_const", hi, 32'hFFFFFFFF);
    check("mult_neg_lo_const", lo, 32'hFFFFFFEB);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 0);
    check("div_neg_lo_const", lo, 32'hFFFFFFFD);
    check("div_neg_hi_const", hi, 32'hFFFFFFFF);
    run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 0, 0);
    check("divu_zero_lo_const", lo, 32'hFFFFFFFF);
    check("divu_zero_hi_const", hi, 32'd100);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("div_ovf_lo_const", lo, 32'h80000000);
    check("div_ovf_hi_const", hi, 32'd0);
    run_op("div_negzero", OP_DIV, 32'hFFFFFFFB, 32'd0, 0, 0);
    run_op("mult_minmin", OP_MULT, 32'h80000000, 32'h80000000, 0, 0);
    run_op("div_negdivisor", OP_DIV, 32'd17, 32'hFFFFFFFB, 0, 0);

    // start and HI write while busy are both dropped
    run_op("disturb", OP_MULTU, 32'd123, 32'd456, 1, 0);

    // IDLE register writes
    lo_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    lo_we = 1'b0;
    m_lo = 32'hA5A5A5A5;
    check("mtlo_lo", lo, m_lo);
    check("mtlo_hi_unchanged", hi, m_hi);
    check("mtlo_busy", 32'(busy), 32'd0);
    hi_we = 1'b1; wdata = 32'h3C3C0F0F;
    @(posedge clk); #1;
    hi_we = 1'b0;
    m_hi = 32'h3C3C0F0F;
    check("mthi_hi", hi, m_hi);
    check("mthi_lo_unchanged", lo, m_lo);

    // start together with a HI write: write lands, then result overwrites
    run_op("we_start", OP_DIVU, 32'd1000, 32'd7, 0, 1);

    // reset in the middle of a DIVU
    md_op = OP_DIVU; data1 = 32'd99999; data2 = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    quiet_bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) quiet_bad = 1;
    end
    check("midrst_no_update", 32'(quiet_bad), 32'd0);
    run_op("after_rst", OP_MULTU, 32'd6, 32'd7, 0, 0);
    check("after_rst_lo_const", lo, 32'd42);
    check("after_rst_hi_const", hi, 32'd0);

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      r_op = 2'($urandom_range(0, 3));
      r_a  = pick_operand();
      r_b  = pick_operand();
      run_op($sformatf("rand%0d", i), r_op, r_a, r_b, ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
